// File: rtl/scarv_cop_aes_pkg.sv
// Shared definitions for the SCARV AES co-processor units (enc and dec).
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package scarv_cop_aes_pkg;

  // Instruction subclass encodings seen on id_subclass.
  localparam logic [4:0] SUBCLASS_SUBDEC = 5'b00010;
  localparam logic [4:0] SUBCLASS_MIXDEC = 5'b00011;

  // Instruction unit FSM state encodings.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_t;

  // Operation latched at accept.
  typedef enum logic {
    OP_SUB = 1'b0,
    OP_MIX = 1'b1
  } aes_op_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/scarv_cop_aes_dec_if.sv
// Dispatch/writeback bundle between the co-processor issuer and the AES decrypt unit.
// Latency: n/a (wiring only).
// Backpressure: issuer holds aes_ivalid until aes_idone; no other stall.
interface scarv_cop_aes_dec_if;

  logic        aes_ivalid;
  logic        aes_idone;
  logic [31:0] aes_rs1;
  logic [4:0]  id_subclass;
  logic [3:0]  aes_cpr_rd_ben;
  logic [31:0] aes_cpr_rd_wdata;

  // Issuer side: drives the instruction, receives the writeback.
  modport master (
    output aes_ivalid,
    output aes_rs1,
    output id_subclass,
    input  aes_idone,
    input  aes_cpr_rd_ben,
    input  aes_cpr_rd_wdata
  );

  // Execution unit side.
  modport slave (
    input  aes_ivalid,
    input  aes_rs1,
    input  id_subclass,
    output aes_idone,
    output aes_cpr_rd_ben,
    output aes_cpr_rd_wdata
  );

endinterface

// File: rtl/scarv_cop_aes_dec_inv_sbox.sv
// Combinational AES inverse S-box, one byte in, one byte out.
// Latency: 0 cycles (pure lookup).
// Backpressure: none.
module scarv_aes_inv_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Element 0 is the leftmost entry, so INV_SBOX[x] is InvSBox(x).
  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/scarv_cop_aes_dec.sv
// AES decrypt-direction word unit: inverse SubBytes / InvMixColumns, one byte per cycle.
// Latency: 5 cycles accept-to-idone for legal ops, 1 cycle for illegal subclasses.
// Backpressure: none; issuer holds aes_ivalid until aes_idone, dropping it mid-run aborts.
module scarv_cop_aes_dec
  import scarv_cop_aes_pkg::*;
(
  input  logic                 g_clk,
  input  logic                 g_reset,
  scarv_cop_aes_dec_if.slave   bus
);

  aes_state_t  state;
  aes_state_t  state_nxt;
  aes_op_t     op;
  logic [1:0]  cnt;
  logic [31:0] src;
  logic [31:0] res;
  logic        illegal;

  logic        sub_legal;
  logic [7:0]  sbox_out;
  logic [7:0]  byte_res;
  logic [7:0]  a    [4];
  logic [7:0]  x2   [4];
  logic [7:0]  x4   [4];
  logic [7:0]  x8   [4];

  assign sub_legal = (bus.id_subclass == SUBCLASS_SUBDEC) ||
                     (bus.id_subclass == SUBCLASS_MIXDEC);

  // The single shared S-box always looks at the byte currently being produced.
  scarv_aes_inv_sbox u_inv_sbox (
    .din  (src[{cnt, 3'b000} +: 8]),
    .dout (sbox_out)
  );

  // Rotate source bytes so a[0] is byte cnt, then form the InvMixColumns row for it.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a[k]  = src[{cnt + 2'(k), 3'b000} +: 8];
      x2[k] = xtime(a[k]);
      x4[k] = xtime(x2[k]);
      x8[k] = xtime(x4[k]);
    end
    if (op == OP_MIX) begin
      byte_res = (x8[0] ^ x4[0] ^ x2[0])         // 0e * a0
               ^ (x8[1] ^ x2[1] ^ a[1])          // 0b * a1
               ^ (x8[2] ^ x4[2] ^ a[2])          // 0d * a2
               ^ (x8[3] ^ a[3]);                 // 09 * a3
    end else begin
      byte_res = sbox_out;
    end
  end

  // FSM state register.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept in IDLE, four byte steps in RUN, one DONE cycle, abort on ivalid drop.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.aes_ivalid) begin
          state_nxt = sub_legal ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (!bus.aes_ivalid) begin
          state_nxt = ST_IDLE;
        end else if (cnt == 2'd3) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch operands at accept, fill one result byte per RUN cycle.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      src     <= 32'h0;
      res     <= 32'h0;
      cnt     <= 2'd0;
      op      <= OP_SUB;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.aes_ivalid) begin
            res <= 32'h0;
            cnt <= 2'd0;
            if (sub_legal) begin
              src     <= bus.aes_rs1;
              op      <= (bus.id_subclass == SUBCLASS_MIXDEC) ? OP_MIX : OP_SUB;
              illegal <= 1'b0;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!bus.aes_ivalid) begin
            res <= 32'h0;
            cnt <= 2'd0;
          end else begin
            res[{cnt, 3'b000} +: 8] <= byte_res;
            cnt                     <= cnt + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Writeback is visible only in DONE and depends on registered state alone.
  always_comb begin
    bus.aes_idone        = 1'b0;
    bus.aes_cpr_rd_ben   = 4'b0000;
    bus.aes_cpr_rd_wdata = 32'h0;
    if (state == ST_DONE) begin
      bus.aes_idone        = 1'b1;
      bus.aes_cpr_rd_ben   = illegal ? 4'b0000 : 4'b1111;
      bus.aes_cpr_rd_wdata = res;
    end
  end

endmodule

// File: tb/tb_scarv_cop_aes_dec.sv
// Directed bench for scarv_cop_aes_dec with hand-computed vectors.
// Latency: checks 5-cycle legal and 1-cycle illegal completion.
// Backpressure: exercises abort by ivalid drop, reset mid-op, back-to-back issue.
module tb_scarv_cop_aes_dec;
  import scarv_cop_aes_pkg::*;

  logic g_clk;
  logic g_reset;
  int   errors;
  int   checks;
  int   cyc;

  scarv_cop_aes_dec_if bus ();

  scarv_cop_aes_dec dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial cyc = 0;
  always @(posedge g_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left #1 after a rising edge. Cycle 0 is the accept cycle.
  // abort_at / reset_at / change_at select the cycle where that disturbance starts (-1: none).
  task automatic run_op(input logic [4:0] sc, input logic [31:0] rs1,
                        input int abort_at, input int reset_at, input int change_at,
                        output int lat, output logic [31:0] wd, output logic [3:0] be);
    lat = -1;
    wd  = 32'hx;
    be  = 4'hx;
    bus.aes_ivalid  = 1'b1;
    bus.aes_rs1     = rs1;
    bus.id_subclass = sc;
    for (int n = 0; n < 13; n++) begin
      if (n == abort_at) bus.aes_ivalid = 1'b0;
      if (n == change_at) begin
        bus.aes_rs1     = ~rs1;
        bus.id_subclass = 5'b11111;
      end
      if (n == reset_at) g_reset = 1'b1;
      if (reset_at >= 0 && n == reset_at + 1) begin
        g_reset        = 1'b0;
        bus.aes_ivalid = 1'b0;
      end
      @(negedge g_clk);
      if (n == reset_at) begin
        check("rst_idone", {31'h0, bus.aes_idone}, 32'h0);
        check("rst_ben", {28'h0, bus.aes_cpr_rd_ben}, 32'h0);
        check("rst_wdata", bus.aes_cpr_rd_wdata, 32'h0);
        check("rst_state", {30'h0, dut.state}, {30'h0, ST_IDLE});
      end
      if (bus.aes_idone) begin
        lat = n;
        wd  = bus.aes_cpr_rd_wdata;
        be  = bus.aes_cpr_rd_ben;
        bus.aes_ivalid = 1'b0;
        @(posedge g_clk);
        #1;
        return;
      end
      @(posedge g_clk);
      #1;
    end
    bus.aes_ivalid = 1'b0;
  endtask

  int          lat;
  int          lat2;
  int          c0;
  int          c1;
  logic [31:0] wd;
  logic [31:0] wd2;
  logic [3:0]  be;

  initial begin
    errors = 0;
    checks = 0;
    g_reset         = 1'b1;
    bus.aes_ivalid  = 1'b0;
    bus.aes_rs1     = 32'h0;
    bus.id_subclass = 5'b0;

    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    check("reset_idone", {31'h0, bus.aes_idone}, 32'h0);
    check("reset_ben", {28'h0, bus.aes_cpr_rd_ben}, 32'h0);
    check("reset_wdata", bus.aes_cpr_rd_wdata, 32'h0);
    @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    @(posedge g_clk);
    #1;

    // SUBDEC: InvSBox(63,7c,77,7b) = 00,01,02,03
    run_op(SUBCLASS_SUBDEC, 32'h7B777C63, -1, -1, -1, lat, wd, be);
    check("sub_lat", lat, 5);
    check("sub_wdata", wd, 32'h03020100);
    check("sub_ben", {28'h0, be}, 32'hF);

    // MIXDEC: column (8e,4d,a1,bc) inverts to (db,13,53,45)
    run_op(SUBCLASS_MIXDEC, 32'hBCA14D8E, -1, -1, -1, lat, wd, be);
    check("mix_lat", lat, 5);
    check("mix_wdata", wd, 32'h455313DB);
    check("mix_ben", {28'h0, be}, 32'hF);

    // 0e^0b^0d^09 = 01
    run_op(SUBCLASS_MIXDEC, 32'h01010101, -1, -1, -1, lat, wd, be);
    check("mix_ones", wd, 32'h01010101);

    // Illegal subclass completes in one cycle with no write enables.
    run_op(5'b11111, 32'hDEADBEEF, -1, -1, -1, lat, wd, be);
    check("ill_lat", lat, 1);
    check("ill_ben", {28'h0, be}, 32'h0);
    check("ill_wdata", wd, 32'h0);

    // Abort: ivalid dropped in cycle 3.
    run_op(SUBCLASS_SUBDEC, 32'h7B777C63, 3, -1, -1, lat, wd, be);
    check("abort_no_done", lat, -1);
    run_op(SUBCLASS_SUBDEC, 32'h7B777C63, -1, -1, -1, lat, wd, be);
    check("post_abort_lat", lat, 5);
    check("post_abort_wdata", wd, 32'h03020100);

    // Reset in cycle 2 of MIXDEC.
    run_op(SUBCLASS_MIXDEC, 32'hBCA14D8E, -1, 2, -1, lat, wd, be);
    check("reset_no_done", lat, -1);
    run_op(SUBCLASS_MIXDEC, 32'hBCA14D8E, -1, -1, -1, lat, wd, be);
    check("post_reset_lat", lat, 5);
    check("post_reset_wdata", wd, 32'h455313DB);

    // Back-to-back SUBDECs; the second has rs1/subclass changed mid-RUN.
    c0 = cyc;
    run_op(SUBCLASS_SUBDEC, 32'h7B777C63, -1, -1, -1, lat, wd, be);
    c1 = cyc;
    run_op(SUBCLASS_SUBDEC, 32'h7B777C63, -1, -1, 2, lat2, wd2, be);
    check("b2b_done1_cycle", lat, 5);
    check("b2b_done2_cycle", (c1 - c0) + lat2, 11);
    check("b2b_wdata1", wd, 32'h03020100);
    check("b2b_wdata2", wd2, 32'h03020100);
    check("b2b_ben2", {28'h0, be}, 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
